flappy_game_ctrl: RTL and testbench
===================================

FLAPPY_GAME_CTRL -- requirements
Module: flappy_game_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  TICK_DIV  500000  clocks per game tick
  SCREEN_W  640     pipe spawn X
  PIPE_W    60      pipe width
  PIPE_SPD  2       pipe X step per tick
  GAP_H     120     vertical gap height
  BIRD_SZ   16      bird box edge
  FLOOR_Y   20      bird Y at or below this is a hit
  CEIL_Y    470     bird Y at or above this is a hit
REQ-002 Ports SHALL be (name, direction, width, meaning):
  Clk       in   1   single clock
  Reset     in   1   asynchronous, active-high reset
  Start     in   1   begin play from INIT
  Ack       in   1   acknowledge loss, return to INIT
  XBird     in   10  bird X from bird datapath
  YBird     in   10  bird Y, Y increases upward
  BirdRun   out  1   enables bird datapath
  BirdClear out  1   holds bird datapath in init
  Tick      out  1   one-cycle game-tick pulse
  PipeX0    out  10  pipe 0 left edge
  PipeX1    out  10  pipe 1 left edge
  GapY0     out  10  pipe 0 gap bottom
  GapY1     out  10  pipe 1 gap bottom
  Score     out  10  pipes passed
  q_Init, q_Play, q_Lost  out  1 each  one-hot state

Function
REQ-003 FSM SHALL be one-hot INIT, PLAY, LOST; INIT->PLAY on Start; PLAY->LOST on hit; LOST->INIT on Ack; Start ignored outside INIT; Ack ignored outside LOST.
REQ-004 INIT SHALL drive BirdClear=1, BirdRun=0, PipeX0=SCREEN_W, PipeX1=SCREEN_W+SCREEN_W/2, GapY0=GapY1=200, Score=0.
REQ-005 PLAY SHALL drive BirdRun=1, BirdClear=0; LOST SHALL drive both 0 and freeze all pipe/score registers.
REQ-006 Tick counter SHALL count 0..TICK_DIV-1 only in PLAY, pulse Tick when it equals TICK_DIV-1, then wrap to 0; outside PLAY it SHALL be 0 and Tick 0.
REQ-007 On Tick, each PipeX SHALL decrease by PIPE_SPD; if PipeX < PIPE_SPD it SHALL reload to SCREEN_W and its GapY SHALL load the next gap value.
REQ-008 Score SHALL increment by 1 per pipe on the Tick where old PipeX+PIPE_W >= XBird and new PipeX+PIPE_W < XBird; Score SHALL saturate at 1023; both pipes crossing on the same Tick SHALL add 2.
REQ-009 Hit SHALL be evaluated every PLAY cycle with 11-bit arithmetic: YBird <= FLOOR_Y, or YBird >= CEIL_Y, or for either pipe (XBird+BIRD_SZ > PipeX and XBird < PipeX+PIPE_W) and (YBird < GapY or YBird+BIRD_SZ > GapY+GAP_H).
REQ-010 Hit and Tick in the same cycle: transition to LOST, pipe move and score update of that Tick SHALL be suppressed.
REQ-011 LOST SHALL be entered exactly one cycle after the hit cycle.

Reset
REQ-012 Reset SHALL asynchronously force INIT, tick counter 0, Tick 0, and the REQ-004 output values.
REQ-013 Reset asserted mid-PLAY or mid-LOST SHALL abort immediately with no score retention.

Configuration
REQ-014 With FLAPPY_PIPE_LFSR_EN defined, gap values SHALL be 80 + lfsr[7:0] from a 16-bit Fibonacci LFSR (taps 16,14,13,11), seed 16'hACE1 on Reset, advanced every clock in all states.
REQ-015 Without FLAPPY_PIPE_LFSR_EN, gap values SHALL cycle through a 4-entry table 100, 220, 160, 300 via a 2-bit index reset to 0 and advanced per reload.

Structure
REQ-016 Package flappy_pkg SHALL hold the state encodings, default screen constants and the gap table.
REQ-017 Sub-module flappy_pipe SHALL own one pipe's X, GapY, reload and pass detection; it SHALL be instantiated twice, with a shared gap source arbitrating pipe 0 first on simultaneous reloads (pipe 1 gets the following value).

Verification (TICK_DIV=4)
REQ-018 Reset, Start=1 one cycle -> q_Play next cycle, Tick every 4th clock, PipeX0 640->638 on first Tick.
REQ-019 XBird=100, YBird=200 held, run until PipeX0+60 drops below 100 -> Score 0->1 on that Tick.
REQ-020 YBird=20 in PLAY -> q_Lost next cycle, BirdRun=0, PipeX0 frozen over 20 clocks; Ack -> q_Init, Score 0.
REQ-021 PipeX0=1 at Tick -> PipeX0=640, GapY0 = next gap value (table mode: 100 first).
REQ-022 Hit coinciding with Tick -> q_Lost, PipeX and Score unchanged.
REQ-023 Reset pulse mid-PLAY between Ticks -> outputs match REQ-004 same cycle, Tick counter 0.

Source files
------------

// File: rtl/flappy_pkg.sv
// Shared state encoding, default screen geometry and gap sequence for the
// flappy game controller.
package flappy_pkg;

   typedef enum logic [2:0] {
      ST_INIT = 3'b001,
      ST_PLAY = 3'b010,
      ST_LOST = 3'b100
   } state_t;

   localparam int unsigned DEF_TICK_DIV = 500000;
   localparam int unsigned DEF_SCREEN_W = 640;
   localparam int unsigned DEF_PIPE_W   = 60;
   localparam int unsigned DEF_PIPE_SPD = 2;
   localparam int unsigned DEF_GAP_H    = 120;
   localparam int unsigned DEF_BIRD_SZ  = 16;
   localparam int unsigned DEF_FLOOR_Y  = 20;
   localparam int unsigned DEF_CEIL_Y   = 470;

   localparam logic [9:0]  GAP_INIT      = 10'd200;
   localparam logic [9:0]  LFSR_GAP_BASE = 10'd80;
   localparam logic [15:0] LFSR_SEED     = 16'hACE1;

   function automatic logic [9:0] gap_table(input logic [1:0] idx);
      logic [9:0] g;
      g = 10'd100;
      unique case (idx)
         2'd0: g = 10'd100;
         2'd1: g = 10'd220;
         2'd2: g = 10'd160;
         2'd3: g = 10'd300;
         default: g = 10'd100;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/flappy_game_ctrl_pipe.sv
// flappy_pipe: one pipe's X position, gap, respawn and bird pass / collision
// detection. All geometry is compared in 11 bits so sums cannot wrap.
module flappy_pipe
   import flappy_pkg::*;
#(
   parameter int unsigned X_INIT   = DEF_SCREEN_W,
   parameter int unsigned SCREEN_W = DEF_SCREEN_W,
   parameter int unsigned PIPE_W   = DEF_PIPE_W,
   parameter int unsigned PIPE_SPD = DEF_PIPE_SPD,
   parameter int unsigned GAP_H    = DEF_GAP_H,
   parameter int unsigned BIRD_SZ  = DEF_BIRD_SZ
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Clear,
   input  logic       Move,
   input  logic [9:0] GapNext,
   input  logic [9:0] XBird,
   input  logic [9:0] YBird,
   output logic [9:0] PipeX,
   output logic [9:0] GapY,
   output logic       Reload,
   output logic       Pass,
   output logic       Hit
);

   localparam logic [9:0]  X_RST   = 10'(X_INIT);
   localparam logic [9:0]  X_SPAWN = 10'(SCREEN_W);
   localparam logic [9:0]  SPD     = 10'(PIPE_SPD);
   localparam logic [10:0] W11     = 11'(PIPE_W);
   localparam logic [10:0] BSZ11   = 11'(BIRD_SZ);
   localparam logic [10:0] GAPH11  = 11'(GAP_H);

   logic [9:0]  x_new;
   logic [10:0] x11, xn11, xb11, yb11, gy11;

   always_comb begin
      Reload = Move && (PipeX < SPD);
      x_new  = Reload ? X_SPAWN : PipeX - SPD;
      x11    = {1'b0, PipeX};
      xn11   = {1'b0, x_new};
      xb11   = {1'b0, XBird};
      yb11   = {1'b0, YBird};
      gy11   = {1'b0, GapY};
      // Pass fires on the move that takes the pipe's right edge from at/past the bird to before it.
      Pass   = Move && (x11 + W11 >= xb11) && (xn11 + W11 < xb11);
      Hit    = (xb11 + BSZ11 > x11) && (xb11 < x11 + W11) &&
               ((yb11 < gy11) || (yb11 + BSZ11 > gy11 + GAPH11));
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         PipeX <= X_RST;
         GapY  <= GAP_INIT;
      end else if (Clear) begin
         PipeX <= X_RST;
         GapY  <= GAP_INIT;
      end else if (Move) begin
         PipeX <= x_new;
         if (Reload) GapY <= GapNext;
      end
   end

endmodule

// File: rtl/flappy_game_ctrl.sv
// Flappy game controller: INIT/PLAY/LOST FSM, tick divider, two pipes and score.
// Define FLAPPY_PIPE_LFSR_EN for LFSR gap heights instead of the fixed table.
module flappy_game_ctrl
   import flappy_pkg::*;
#(
   parameter int unsigned TICK_DIV = DEF_TICK_DIV,
   parameter int unsigned SCREEN_W = DEF_SCREEN_W,
   parameter int unsigned PIPE_W   = DEF_PIPE_W,
   parameter int unsigned PIPE_SPD = DEF_PIPE_SPD,
   parameter int unsigned GAP_H    = DEF_GAP_H,
   parameter int unsigned BIRD_SZ  = DEF_BIRD_SZ,
   parameter int unsigned FLOOR_Y  = DEF_FLOOR_Y,
   parameter int unsigned CEIL_Y   = DEF_CEIL_Y
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Start,
   input  logic       Ack,
   input  logic [9:0] XBird,
   input  logic [9:0] YBird,
   output logic       BirdRun,
   output logic       BirdClear,
   output logic       Tick,
   output logic [9:0] PipeX0,
   output logic [9:0] PipeX1,
   output logic [9:0] GapY0,
   output logic [9:0] GapY1,
   output logic [9:0] Score,
   output logic       q_Init,
   output logic       q_Play,
   output logic       q_Lost
);

   localparam int unsigned CW      = $clog2(TICK_DIV + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
   localparam logic [10:0] FLOOR11 = 11'(FLOOR_Y);
   localparam logic [10:0] CEIL11  = 11'(CEIL_Y);

   state_t        state, state_next;
   logic [CW-1:0] cnt;
   logic          hit, move, clear;
   logic          hit0, hit1, pass0, pass1, reload0, reload1;
   logic [9:0]    gap_a, gap_b, gap1;
   logic [1:0]    inc;
   logic [10:0]   score_sum;

   assign q_Init = (state == ST_INIT);
   assign q_Play = (state == ST_PLAY);
   assign q_Lost = (state == ST_LOST);

   assign hit   = q_Play && (({1'b0, YBird} <= FLOOR11) || ({1'b0, YBird} >= CEIL11) || hit0 || hit1);
   assign Tick  = q_Play && (cnt == CNT_MAX);
   // A hit on the tick cycle wins: no pipe motion or scoring on the way into LOST.
   assign move  = Tick && !hit;
   assign clear = q_Lost && Ack;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= ST_INIT;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      BirdRun    = 1'b0;
      BirdClear  = 1'b0;
      unique case (state)
         ST_INIT: begin
            BirdClear = 1'b1;
            if (Start) state_next = ST_PLAY;
         end
         ST_PLAY: begin
            BirdRun = 1'b1;
            if (hit) state_next = ST_LOST;
         end
         ST_LOST: begin
            if (Ack) state_next = ST_INIT;
         end
         default: state_next = ST_INIT;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)                cnt <= '0;
      else if (q_Play && !hit)  cnt <= (cnt == CNT_MAX) ? '0 : cnt + CW'(1);
      else                      cnt <= '0;
   end

`ifdef FLAPPY_PIPE_LFSR_EN
   logic [15:0] lfsr, lfsr_nxt;

   assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   assign gap_a    = LFSR_GAP_BASE + {2'b00, lfsr[7:0]};
   assign gap_b    = LFSR_GAP_BASE + {2'b00, lfsr_nxt[7:0]};

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) lfsr <= LFSR_SEED;
      else       lfsr <= lfsr_nxt;
   end
`else
   logic [1:0] gidx;

   assign gap_a = gap_table(gidx);
   assign gap_b = gap_table(gidx + 2'd1);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) gidx <= '0;
      else       gidx <= gidx + {1'b0, reload0} + {1'b0, reload1};
   end
`endif

   // Pipe 0 takes the current gap; pipe 1 takes the following one if both respawn together.
   assign gap1 = reload0 ? gap_b : gap_a;

   flappy_pipe #(
      .X_INIT   (SCREEN_W),
      .SCREEN_W (SCREEN_W),
      .PIPE_W   (PIPE_W),
      .PIPE_SPD (PIPE_SPD),
      .GAP_H    (GAP_H),
      .BIRD_SZ  (BIRD_SZ)
   ) u_pipe0 (
      .Clk     (Clk),
      .Reset   (Reset),
      .Clear   (clear),
      .Move    (move),
      .GapNext (gap_a),
      .XBird   (XBird),
      .YBird   (YBird),
      .PipeX   (PipeX0),
      .GapY    (GapY0),
      .Reload  (reload0),
      .Pass    (pass0),
      .Hit     (hit0)
   );

   flappy_pipe #(
      .X_INIT   (SCREEN_W + SCREEN_W / 2),
      .SCREEN_W (SCREEN_W),
      .PIPE_W   (PIPE_W),
      .PIPE_SPD (PIPE_SPD),
      .GAP_H    (GAP_H),
      .BIRD_SZ  (BIRD_SZ)
   ) u_pipe1 (
      .Clk     (Clk),
      .Reset   (Reset),
      .Clear   (clear),
      .Move    (move),
      .GapNext (gap1),
      .XBird   (XBird),
      .YBird   (YBird),
      .PipeX   (PipeX1),
      .GapY    (GapY1),
      .Reload  (reload1),
      .Pass    (pass1),
      .Hit     (hit1)
   );

   assign inc       = {1'b0, pass0} + {1'b0, pass1};
   assign score_sum = {1'b0, Score} + {9'd0, inc};

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)      Score <= '0;
      else if (clear) Score <= '0;
      else if (move)  Score <= score_sum[10] ? '1 : score_sum[9:0];
   end

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Self-checking bench for flappy_game_ctrl (table gap mode, TICK_DIV=4) against
// a behavioural game model.
module tb_flappy_game_ctrl;

   localparam int TD = 4, SW = 640, PW = 60, PS = 2, GH = 120, BS = 16, FY = 20, CY = 470;

   logic       Clk = 1'b0;
   logic       Reset, Start, Ack;
   logic [9:0] XBird, YBird;
   logic       BirdRun, BirdClear, Tick, q_Init, q_Play, q_Lost;
   logic [9:0] PipeX0, PipeX1, GapY0, GapY1, Score;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model: 0 = waiting, 1 = playing, 2 = lost
   int m_state, m_cnt, m_score, m_reloads;
   int m_px[2];
   int m_gy[2];
   int gap_tab[4] = '{100, 220, 160, 300};

   flappy_game_ctrl #(.TICK_DIV(TD)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack),
      .XBird(XBird), .YBird(YBird),
      .BirdRun(BirdRun), .BirdClear(BirdClear), .Tick(Tick),
      .PipeX0(PipeX0), .PipeX1(PipeX1), .GapY0(GapY0), .GapY1(GapY1),
      .Score(Score), .q_Init(q_Init), .q_Play(q_Play), .q_Lost(q_Lost)
   );

   always #5 Clk = ~Clk;

   function automatic void model_new_game();
      m_px[0] = SW;
      m_px[1] = SW + SW / 2;
      m_gy[0] = 200;
      m_gy[1] = 200;
      m_score = 0;
      m_cnt   = 0;
   endfunction

   function automatic void model_reset();
      m_state   = 0;
      m_reloads = 0;
      model_new_game();
   endfunction

   function automatic bit bird_in_pipe(int p, int xb, int yb);
      return (xb + BS > m_px[p]) && (xb < m_px[p] + PW) &&
             ((yb < m_gy[p]) || (yb + BS > m_gy[p] + GH));
   endfunction

   function automatic void model_update();
      int xb, yb, nx;
      bit crash, tk;
      xb = int'(XBird);
      yb = int'(YBird);
      case (m_state)
         0: if (Start) begin m_state = 1; m_cnt = 0; end
         1: begin
            crash = (yb <= FY) || (yb >= CY) || bird_in_pipe(0, xb, yb) || bird_in_pipe(1, xb, yb);
            tk    = (m_cnt == TD - 1);
            if (crash) begin
               m_state = 2;
               m_cnt   = 0;
            end else begin
               m_cnt = tk ? 0 : m_cnt + 1;
               if (tk) begin
                  for (int p = 0; p < 2; p++) begin
                     if (m_px[p] < PS) begin
                        nx = SW;
                        m_gy[p] = gap_tab[m_reloads % 4];
                        m_reloads++;
                     end else nx = m_px[p] - PS;
                     if ((m_px[p] + PW >= xb) && (nx + PW < xb) && m_score < 1023) m_score++;
                     m_px[p] = nx;
                  end
               end
            end
         end
         default: if (Ack) begin m_state = 0; model_new_game(); end
      endcase
   endfunction

   task automatic cyc();
      @(posedge Clk);
      model_update();
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b1; Start = 1'b0; Ack = 1'b0; XBird = 10'd100; YBird = 10'd200;
      model_reset();
      #2;
      n_tests++;
      if ({q_Init, q_Play, q_Lost, BirdClear, BirdRun, Tick} !== 6'b100100) begin
         n_fail++;
         $display("FAIL reset_ctrl got=%b want=100100", {q_Init, q_Play, q_Lost, BirdClear, BirdRun, Tick});
      end
      n_tests++;
      if ({PipeX0, PipeX1, GapY0, GapY1, Score} !== {10'd640, 10'd960, 10'd200, 10'd200, 10'd0}) begin
         n_fail++;
         $display("FAIL reset_data got x0=%0d x1=%0d g0=%0d g1=%0d s=%0d want 640 960 200 200 0",
                  PipeX0, PipeX1, GapY0, GapY1, Score);
      end
      cyc(); cyc();
      Reset = 1'b0;
      cyc(); cyc();
      n_tests++;
      if ({q_Init, Tick, PipeX0} !== {1'b1, 1'b0, 10'd640}) begin
         n_fail++;
         $display("FAIL idle_init got init=%b tick=%b x0=%0d want 1 0 640", q_Init, Tick, PipeX0);
      end
   endtask

   task automatic test_start_tick();
      Start = 1'b1;
      cyc();
      Start = 1'b0;
      n_tests++;
      if ({q_Play, BirdRun, BirdClear, Tick} !== 4'b1100) begin
         n_fail++;
         $display("FAIL start_play got=%b want=1100", {q_Play, BirdRun, BirdClear, Tick});
      end
      for (int i = 1; i <= 3; i++) begin
         cyc();
         n_tests++;
         if (Tick !== (i == 3)) begin
            n_fail++;
            $display("FAIL tick_phase cyc=%0d got=%b want=%b", i, Tick, (i == 3));
         end
      end
      cyc();
      n_tests++;
      if ({PipeX0, PipeX1, Tick} !== {10'd638, 10'd958, 1'b0}) begin
         n_fail++;
         $display("FAIL first_move got x0=%0d x1=%0d tick=%b want 638 958 0", PipeX0, PipeX1, Tick);
      end
   endtask

   task automatic test_score();
      bit found = 0;
      XBird = 10'd100; YBird = 10'd200;
      for (int i = 0; i < 2000 && !found; i++) begin
         cyc();
         if (m_px[0] == 40) found = 1;
      end
      n_tests++;
      if (!found || Score !== 10'd0 || PipeX0 !== 10'd40) begin
         n_fail++;
         $display("FAIL score_before found=%0d got s=%0d x0=%0d want 0 40", found, Score, PipeX0);
      end
      found = 0;
      for (int i = 0; i < 8 && !found; i++) begin
         cyc();
         if (m_px[0] == 38) found = 1;
      end
      n_tests++;
      if (!found || Score !== 10'd1 || PipeX0 !== 10'd38 || q_Play !== 1'b1) begin
         n_fail++;
         $display("FAIL score_pass found=%0d got s=%0d x0=%0d play=%b want 1 38 1", found, Score, PipeX0, q_Play);
      end
   endtask

   task automatic test_floor_hit();
      int px0, sc;
      YBird = 10'd20;
      px0 = m_px[0];
      sc  = m_score;
      cyc();
      YBird = 10'd200;
      n_tests++;
      if ({q_Lost, BirdRun, BirdClear} !== 3'b100) begin
         n_fail++;
         $display("FAIL floor_lost got=%b want=100", {q_Lost, BirdRun, BirdClear});
      end
      Start = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cyc();
         n_tests++;
         if (PipeX0 !== 10'(px0) || Score !== 10'(sc) || q_Lost !== 1'b1 || Tick !== 1'b0) begin
            n_fail++;
            $display("FAIL lost_frozen cyc=%0d got x0=%0d s=%0d lost=%b tick=%b want %0d %0d 1 0",
                     i, PipeX0, Score, q_Lost, Tick, px0, sc);
         end
      end
      Start = 1'b0;
      Ack = 1'b1;
      cyc();
      Ack = 1'b0;
      n_tests++;
      if ({q_Init, BirdClear, Score, PipeX0} !== {1'b1, 1'b1, 10'd0, 10'd640}) begin
         n_fail++;
         $display("FAIL ack_init got init=%b clr=%b s=%0d x0=%0d want 1 1 0 640", q_Init, BirdClear, Score, PipeX0);
      end
   endtask

   task automatic test_reload();
      bit found = 0;
      cyc();
      #2 Reset = 1'b1;
      model_reset();
      #2 Reset = 1'b0;
      XBird = 10'd100; YBird = 10'd200;
      cyc();
      Start = 1'b1;
      cyc();
      Start = 1'b0;
      for (int i = 0; i < 1500 && !found; i++) begin
         cyc();
         if (m_reloads == 1) found = 1;
      end
      n_tests++;
      if (!found || PipeX0 !== 10'd640 || GapY0 !== 10'd100) begin
         n_fail++;
         $display("FAIL reload0 found=%0d got x0=%0d g0=%0d want 640 100", found, PipeX0, GapY0);
      end
      found = 0;
      for (int i = 0; i < 1000 && !found; i++) begin
         cyc();
         if (m_reloads == 2) found = 1;
      end
      n_tests++;
      if (!found || PipeX1 !== 10'd640 || GapY1 !== 10'd220 || Score !== 10'd2) begin
         n_fail++;
         $display("FAIL reload1 found=%0d got x1=%0d g1=%0d s=%0d want 640 220 2", found, PipeX1, GapY1, Score);
      end
   endtask

   task automatic test_hit_on_tick();
      bit found = 0;
      int px0, px1, sc;
      for (int i = 0; i < 10 && !found; i++) begin
         cyc();
         if (m_state == 1 && m_cnt == TD - 1) found = 1;
      end
      n_tests++;
      if (!found || Tick !== 1'b1) begin
         n_fail++;
         $display("FAIL tick_align found=%0d got tick=%b want 1", found, Tick);
      end
      px0 = m_px[0]; px1 = m_px[1]; sc = m_score;
      YBird = 10'd470;
      cyc();
      YBird = 10'd200;
      n_tests++;
      if (q_Lost !== 1'b1 || PipeX0 !== 10'(px0) || PipeX1 !== 10'(px1) || Score !== 10'(sc)) begin
         n_fail++;
         $display("FAIL hit_on_tick got lost=%b x0=%0d x1=%0d s=%0d want 1 %0d %0d %0d",
                  q_Lost, PipeX0, PipeX1, Score, px0, px1, sc);
      end
      Ack = 1'b1;
      cyc();
      Ack = 1'b0;
   endtask

   task automatic test_reset_mid_play();
      Start = 1'b1;
      cyc();
      Start = 1'b0;
      cyc(); cyc();
      #2 Reset = 1'b1;
      model_reset();
      #1;
      n_tests++;
      if ({q_Init, q_Play, BirdClear, BirdRun, Tick, PipeX0, PipeX1, GapY0, Score} !==
          {5'b10100, 10'd640, 10'd960, 10'd200, 10'd0}) begin
         n_fail++;
         $display("FAIL reset_mid_play got init=%b play=%b tick=%b x0=%0d x1=%0d g0=%0d s=%0d want 1 0 0 640 960 200 0",
                  q_Init, q_Play, Tick, PipeX0, PipeX1, GapY0, Score);
      end
      #1 Reset = 1'b0;
      cyc();
      Start = 1'b1;
      cyc();
      Start = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         cyc();
         n_tests++;
         if (Tick !== (i == 3)) begin
            n_fail++;
            $display("FAIL post_reset_tick cyc=%0d got=%b want=%b", i, Tick, (i == 3));
         end
      end
   endtask

   task automatic test_random();
      logic [5:0] want_ctrl;
      for (int i = 0; i < 4000; i++) begin
         Start = ($urandom_range(0, 7) == 0);
         Ack   = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 15) == 0) begin
            XBird = 10'($urandom_range(0, 400));
            YBird = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(120, 320));
         end
         cyc();
         if ($urandom_range(0, 599) == 0) begin
            Reset = 1'b1;
            model_reset();
            #2 Reset = 1'b0;
         end
         want_ctrl = {m_state == 0, m_state == 1, m_state == 2, m_state == 1, m_state == 0,
                      m_state == 1 && m_cnt == TD - 1};
         n_tests++;
         if ({q_Init, q_Play, q_Lost, BirdRun, BirdClear, Tick} !== want_ctrl) begin
            n_fail++;
            $display("FAIL rand_ctrl cyc=%0d got=%b want=%b", i,
                     {q_Init, q_Play, q_Lost, BirdRun, BirdClear, Tick}, want_ctrl);
         end
         n_tests++;
         if (PipeX0 !== 10'(m_px[0]) || PipeX1 !== 10'(m_px[1]) || GapY0 !== 10'(m_gy[0]) ||
             GapY1 !== 10'(m_gy[1]) || Score !== 10'(m_score)) begin
            n_fail++;
            $display("FAIL rand_data cyc=%0d got %0d %0d %0d %0d %0d want %0d %0d %0d %0d %0d", i,
                     PipeX0, PipeX1, GapY0, GapY1, Score, m_px[0], m_px[1], m_gy[0], m_gy[1], m_score);
         end
      end
   endtask

   initial begin
      test_reset();
      test_start_tick();
      test_score();
      test_floor_hit();
      test_reload();
      test_hit_on_tick();
      test_reset_mid_play();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
